// File: rtl/pri_enc_pkg.sv
// Shared types and helpers for the priority arbiter/encoder.
// Holds the index-width rule and the operating-mode encoding.
package pri_enc_pkg;

   typedef enum logic {
      PRI_FIXED = 1'b0,
      PRI_RR    = 1'b1
   } pri_mode_e;

   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic logic [7:0] onehot_to_idx(input logic [255:0] oh);
      logic [7:0] idx;
      idx = '0;
      for (int i = 0; i < 256; i++) begin
         if (oh[i]) idx = 8'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/pri_rot_search.sv
// Combinational circular priority search starting at ptr.
// Rotates req so ptr lands on the MSB, scans MSB-first, un-rotates.
module pri_rot_search
   import pri_enc_pkg::*;
#(
   parameter int N    = 8,
   parameter int IDXW = idx_w(N)
) (
   input  logic [N-1:0]    req,
   input  logic [IDXW-1:0] ptr,
   output logic            found,
   output logic [IDXW-1:0] idx
);

   logic [N-1:0]    rot;
   logic [IDXW-1:0] off;
   int              c;
   int              d;

   always_comb begin
      rot   = '0;
      off   = '0;
      found = 1'b0;
      c     = 0;
      d     = 0;
      // rot[N-1-k] holds the k-th candidate in search order
      for (int k = 0; k < N; k++) begin
         c = int'(ptr) - k;
         if (c < 0) c = c + N;
         rot[N-1-k] = req[IDXW'(c)];
      end
      for (int j = 0; j < N; j++) begin
         if (rot[j]) begin
            found = 1'b1;
            off   = IDXW'(N - 1 - j);
         end
      end
      d = int'(ptr) - int'(off);
      if (d < 0) d = d + N;
      idx = IDXW'(d);
   end

endmodule

// File: rtl/pri_arb_encoder.sv
// Registered N-way priority encoder with optional round-robin rotation.
// Winner is held on the outputs until the consumer accepts it.
module pri_arb_encoder
   import pri_enc_pkg::*;
#(
   parameter int N    = 8,
   parameter int IDXW = idx_w(N),
   parameter int RR   = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req,
   input  logic            out_ready,
   output logic            out_valid,
   output logic [IDXW-1:0] out_idx,
   output logic [N-1:0]    out_onehot
);

   localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);
   localparam logic [N-1:0]    ONE  = N'(1);
   localparam pri_mode_e       MODE = (RR != 0) ? PRI_RR : PRI_FIXED;

   logic            valid_q, valid_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic [N-1:0]    oh_q, oh_d;
   logic [IDXW-1:0] ptr_q, ptr_d;
   logic            load;
   logic            hs;
   logic            s_found;
   logic [IDXW-1:0] s_idx;

   assign load = !valid_q || out_ready;
   assign hs   = valid_q && out_ready;

   // Updated ptr feeds the search so back-to-back grants rotate
   always_comb begin
      ptr_d = ptr_q;
      if (MODE == PRI_RR && hs) begin
         ptr_d = (idx_q == '0) ? LAST : idx_q - 1'b1;
      end
   end

   pri_rot_search #(
      .N    (N),
      .IDXW (IDXW)
   ) u_search (
      .req   (req),
      .ptr   (ptr_d),
      .found (s_found),
      .idx   (s_idx)
   );

   always_comb begin
      valid_d = valid_q;
      idx_d   = idx_q;
      oh_d    = oh_q;
      if (load) begin
         valid_d = s_found;
         idx_d   = s_found ? s_idx : '0;
         oh_d    = s_found ? (ONE << s_idx) : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         idx_q   <= '0;
         oh_q    <= '0;
         ptr_q   <= LAST;
      end else begin
         valid_q <= valid_d;
         idx_q   <= idx_d;
         oh_q    <= oh_d;
         ptr_q   <= ptr_d;
      end
   end

   assign out_valid  = valid_q;
   assign out_idx    = idx_q;
   assign out_onehot = oh_q;

endmodule

// File: doc/pri_arb_encoder.md
# pri_arb_encoder

Parametrised, registered priority encoder with an optional round-robin mode and a valid/ready output handshake. It generalises the 8-to-3 combinational encoder to N requesters, and it registers and holds each encoded winner until a downstream consumer accepts it. It sits between a bank of request lines (interrupt sources, FIFO-not-empty flags) and a single consumer that services one requester at a time.

## Interface
- N, default 8: number of request lines; legal range 2..256.
- IDXW, default $clog2(N): width of the encoded index. Derived only; never overridden.
- RR, default 0: 0 = fixed priority, where the highest index wins. 1 = round-robin rotation after each accepted grant.
- clk  in  1: the only clock; all state changes on its rising edge.
- rst_n  in  1: reset; synchronous, active-low.
- req  in  N: request vector; bit i set means requester i is pending. Sampled only on load cycles.
- out_ready  in  1: consumer accepts the current result when it is high while out_valid is high.
- out_valid  out  1: a registered winner is present.
- out_idx  out  IDXW: binary index of the winner.
- out_onehot  out  N: one-hot form of out_idx; all zero when out_valid = 0.

## Operation
- The load condition is `load = !out_valid || out_ready`.
- On a load cycle the block samples `req` and computes the winner.
  - Next-cycle out_valid = |req.
  - out_idx gets the winner index; out_onehot gets 1<<winner.
  - If req == 0: out_valid goes to 0, out_idx to 0 and out_onehot to 0.
- When the load condition is false, the outputs hold, stable and bit-exact, and req is ignored.
- Search order is defined by the start pointer `ptr` (IDXW bits):
  - The candidate order is ptr, ptr-1, …, 0, N-1, …, ptr+1, wrapping modulo N.
  - The first set bit in that order wins.
- Fixed mode (RR = 0): ptr is constant N-1, so the highest set index wins. For N = 8 this is identical to the legacy casex encoder whenever req != 0.
- Round-robin mode (RR = 1): ptr updates only on a handshake (out_valid && out_ready).
  - The new ptr is (out_idx == 0) ? N-1 : out_idx-1.
  - The just-served requester therefore drops to lowest priority.
  - ptr does not change on load cycles where req == 0, or while the output stalls.
- Simultaneous handshake and reload in the same cycle: the new winner is computed with the *updated* ptr. The next-ptr value feeds the search combinationally, so back-to-back grants rotate correctly.
- req changing while out_valid = 1 and out_ready = 0 has no effect. A requester that deasserts during a stall is still reported; the consumer tolerates stale grants.
- Non-power-of-2 N: out_idx never exceeds N-1, and the ptr wrap uses N-1, not 2^IDXW-1.

## Timing
- Latency is 1 cycle from req being sampled on a load cycle to out_valid/out_idx being visible.
- Throughput is one grant per cycle while out_ready stays high.
- Reset (rst_n = 0 at a rising edge) forces: out_valid = 0, out_idx = 0, out_onehot = 0, ptr = N-1.
- Reset takes precedence over any handshake in the same cycle.
- Reset asserted mid-stall discards the held result; after release, the first load uses ptr = N-1.
- All outputs are driven directly from flops; there is no combinational path from req or out_ready to any output.
- The only combinational input-to-state path is the search logic.

## Structure
- Shared package `pri_enc_pkg`:
  - `localparam` helper function `idx_w(n)` (clog2 with a minimum of 1).
  - Typedef `pri_mode_e {PRI_FIXED = 0, PRI_RR = 1}`.
  - Function `onehot_to_idx`.
- One natural sub-module, `pri_rot_search`, purely combinational.
  - Inputs: req[N] and start ptr. Outputs: found and idx.
  - Implementation: rotate req right by ptr-relative offset, run a fixed MSB-first scan, then un-rotate the index modulo N.
  - The top level holds only the flops, the ptr update and the handshake.

## Test plan
1. Fixed mode, N = 8, out_ready = 1; apply req = 8'b0010_0110, then 8'b0000_0001, then 8'h00 → out_idx = 5, then 0, with out_valid = 1 one cycle after each input; the zero vector gives out_valid = 0.
2. Backpressure: req = 8'h81, out_ready = 0 for 4 cycles while req changes to 8'h02 → out_idx holds at 7 throughout; after out_ready rises, the next output is out_idx = 1.
3. Round-robin, N = 8, req held at 8'hFF, out_ready = 1 → out_idx sequence is 7, 6, 5, 4, 3, 2, 1, 0, 7 on consecutive cycles.
4. Round-robin with sparse req = 8'b1000_0100, held → grants alternate 7, 2, 7, 2; ptr does not move during a 3-cycle out_ready = 0 stall inserted after the first 2.
5. N = 5, RR = 1, req = 5'b10001 → grants alternate 4, 0; out_idx never exceeds 4; check the wrap from idx 0 to ptr = 4.
6. Reset mid-operation: during an RR stall with out_idx = 3, pull rst_n low for 1 cycle → next cycle out_valid = 0, out_onehot = 0; with req = 8'hFF afterwards, the first grant is 7.
